// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// Iterative signed 32x32 multiply / 32/32 divide unit. One iteration is
// retired per clock, 32 iterations per operation, so a result appears in the
// cycle after the 32nd rising edge following the start edge. Both operations
// work on operand magnitudes and apply the result sign at the end.
//
// Ports
//   clk        in   1  single clock, rising-edge active
//   reset      in   1  synchronous active-high reset
//   ctrl_MULT  in   1  start signed multiply (wins over ctrl_DIV)
//   ctrl_DIV   in   1  start signed divide
//   operandA   in  32  multiplicand / dividend
//   operandB   in  32  multiplier / divisor
//   ins_in     in  32  instruction tag of the issuing op
//   result     out 32  low product word or quotient
//   exception  out  1  multiply overflow, divide-by-zero or divide overflow
//   ready      out  1  one-cycle completion pulse
//   ins_out    out 32  tag of the completed op
//   busy       out  1  operation in progress
// -----------------------------------------------------------------------------
module multdiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [31:0] ins_in,
  output logic [31:0] result,
  output logic        exception,
  output logic        ready,
  output logic [31:0] ins_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q;

  // Shared datapath registers.
  //   multiply: opnd_q = |A| (multiplicand), {acc_hi_q, acc_lo_q} = partial
  //             product with |B| shifting out of acc_lo_q LSB-first.
  //   divide:   opnd_q = |B| (divisor), acc_hi_q = partial remainder,
  //             acc_lo_q = |A| shifting out MSB-first while quotient bits
  //             shift in at the bottom.
  logic [31:0] acc_hi_q, acc_lo_q, opnd_q, tag_q;
  logic        neg_q;        // result sign: sign(A) xor sign(B)
  logic        div_zero_q;   // divisor was zero
  logic        div_ovf_q;    // 0x80000000 / -1

  logic        start, last_iter, finish;
  logic [31:0] a_mag, b_mag;

  // Iteration results
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [32:0] div_shift;
  logic        div_take;
  logic [31:0] div_hi, div_lo;
  logic [31:0] step_hi, step_lo;

  // Final sign-corrected values, valid on the last iteration
  logic [63:0] prod_mag, prod_s;
  logic [32:0] prod_top;
  logic        mul_exc;
  logic [31:0] quo_s;
  logic [31:0] fin_result;
  logic        fin_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign busy      = (state_q == MULT) || (state_q == DIV);
  assign ready     = (state_q == DONE);
  assign last_iter = (cnt_q == LAST_ITER);
  // A start edge during the last iteration aborts, so no completion then.
  assign finish    = busy && last_iter && !start;

  // Magnitudes; 0x80000000 maps onto itself, which is the correct unsigned
  // magnitude 2^31.
  assign a_mag = operandA[31] ? (~operandA + 32'd1) : operandA;
  assign b_mag = operandB[31] ? (~operandB + 32'd1) : operandB;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
    end else begin
      case (state_q)
        MULT, DIV: if (last_iter) state_d = DONE;
        DONE:      state_d = IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration of shift-add multiply and restoring divide
  // ---------------------------------------------------------------------------
  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the 64-bit {hi, lo} pair right by one (carry enters hi MSB).
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_hi  = mul_sum[32:1];
    mul_lo  = {mul_sum[0], acc_lo_q[31:1]};

    // Divide: bring down the next dividend bit and subtract the divisor when
    // it fits. The remainder stays below the divisor, so a 32-bit subtract
    // suffices once the 33-bit compare has decided.
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_take  = (div_shift >= {1'b0, opnd_q});
    div_hi    = div_take ? (div_shift[31:0] - opnd_q) : div_shift[31:0];
    div_lo    = {acc_lo_q[30:0], div_take};

    step_hi = (state_q == MULT) ? mul_hi : div_hi;
    step_lo = (state_q == MULT) ? mul_lo : div_lo;
  end

  // ---------------------------------------------------------------------------
  // Sign correction and exception detection for the completing op
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_mag = {mul_hi, mul_lo};
    prod_s   = neg_q ? (~prod_mag + 64'd1) : prod_mag;
    // Product fits in 32 signed bits only if bits [63:31] are a sign run.
    prod_top = prod_s[63:31];
    mul_exc  = !((prod_top == '0) || (prod_top == '1));
    quo_s    = neg_q ? (~div_lo + 32'd1) : div_lo;

    fin_result = '0;
    fin_exc    = 1'b0;
    if (state_q == MULT) begin
      fin_result = prod_s[31:0];
      fin_exc    = mul_exc;
    end else if (div_zero_q) begin
      fin_exc = 1'b1;
    end else begin
      // 0x80000000 / -1 yields magnitude 2^31 with positive sign, which
      // already reads back as 0x80000000; only the flag is needed.
      fin_result = quo_s;
      fin_exc    = div_ovf_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: these registers are deliberately not reset; every start edge
    // loads them before they are used, and outputs never expose them
    // directly.
    if (start) begin
      tag_q      <= ins_in;
      acc_hi_q   <= '0;
      neg_q      <= operandA[31] ^ operandB[31];
      div_zero_q <= (operandB == '0);
      div_ovf_q  <= (operandA == 32'h8000_0000) && (operandB == '1);
      if (ctrl_MULT) begin
        opnd_q   <= a_mag;
        acc_lo_q <= b_mag;
      end else begin
        opnd_q   <= b_mag;
        acc_lo_q <= a_mag;
      end
    end else if (busy) begin
      acc_hi_q <= step_hi;
      acc_lo_q <= step_lo;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: change only on a completion edge or reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      exception <= 1'b0;
      ins_out   <= '0;
    end else if (finish) begin
      result    <= fin_result;
      exception <= fin_exc;
      ins_out   <= tag_q;
    end
  end

endmodule
